// File: rtl/axi4s_pattern_pkg.sv
// Shared types and helpers for the AXI4-Stream pattern source: FSM states, payload modes,
// the Galois LFSR step and the last-beat byte-qualifier mask.
package axi4s_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] next_lfsr(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Low 'bytes' lanes set, or all 'width' lanes when bytes is 0.
    function automatic logic [63:0] keep_mask(input int unsigned bytes, input int unsigned width);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width && (bytes == 0 || i < bytes)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4s_pattern_gen.sv
// 32-bit payload generator: loads the seed, then steps on each advance (counter, LFSR or hold).
// Value is registered; a load takes effect the cycle after it is requested.
module axi4s_pattern_gen
    import axi4s_pattern_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  mode_t       mode,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 32'h0;
        end else if (load) begin
            // An all-zero LFSR would lock up, so a zero seed starts at 1
            value <= (mode == MODE_LFSR && seed == 32'h0) ? 32'h1 : seed;
        end else if (adv) begin
            case (mode)
                MODE_INC:  value <= value + 32'h1;
                MODE_LFSR: value <= next_lfsr(value);
                default:   value <= value;
            endcase
        end
    end

endmodule

// File: rtl/axi4s_pattern_src.sv
// AXI4-Stream packet source: runs of framed packets with programmable payload and inter-beat gap.
// One-cycle start latency, one beat per cycle at full rate; beats hold stable while TREADY is low.
module axi4s_pattern_src
    import axi4s_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 4,
    parameter int KB_WIDTH   = ($clog2(DATA_WIDTH/8) > 1) ? $clog2(DATA_WIDTH/8) : 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cfg_start,
    input  logic [LEN_WIDTH-1:0]      cfg_len,
    input  logic [CNT_WIDTH-1:0]      cfg_num,
    input  logic [1:0]                cfg_mode,
    input  logic [31:0]               cfg_seed,
    input  logic [GAP_WIDTH-1:0]      cfg_gap,
    input  logic [KB_WIDTH-1:0]       cfg_last_bytes,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      TVALID,
    input  logic                      TREADY,
    output logic [DATA_WIDTH-1:0]     TDATA,
    output logic [DATA_WIDTH/8-1:0]   TKEEP,
    output logic                      TLAST
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int REPS   = (DATA_WIDTH + 31) / 32;

    state_t                state, state_nxt;
    mode_t                 mode_q;
    logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
    logic [CNT_WIDTH-1:0]  num_q, pkt_cnt;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
    logic [KB_WIDTH-1:0]   last_bytes_q;
    logic [31:0]           pat_value;
    mode_t                 gen_mode;

    logic hs, start_ok, last_beat, last_pkt;

    assign hs        = TVALID && TREADY;
    assign start_ok  = cfg_start && (cfg_len != '0) && (cfg_num != '0);
    assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));
    assign last_pkt  = (pkt_cnt == num_q - CNT_WIDTH'(1));

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = SEND;
            SEND: begin
                if (hs) begin
                    if (last_beat && last_pkt) state_nxt = IDLE;
                    else if (gap_q != '0)      state_nxt = GAP;
                end
            end
            GAP:  if (gap_cnt == GAP_WIDTH'(1)) state_nxt = SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        TVALID = (state == SEND);
        busy   = (state != IDLE);
        TLAST  = (state == SEND) && last_beat;
        TKEEP  = TLAST ? KEEP_W'(keep_mask(32'(last_bytes_q), KEEP_W)) : {KEEP_W{1'b1}};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mode_q       <= MODE_INC;
            len_q        <= '0;
            num_q        <= '0;
            gap_q        <= '0;
            last_bytes_q <= '0;
            beat_cnt     <= '0;
            pkt_cnt      <= '0;
            gap_cnt      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= (state == SEND) && hs && last_beat && last_pkt;
            err  <= cfg_start && ((state != IDLE) || (cfg_len == '0) || (cfg_num == '0));
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mode_q       <= mode_t'(cfg_mode);
                        len_q        <= cfg_len;
                        num_q        <= cfg_num;
                        gap_q        <= cfg_gap;
                        last_bytes_q <= cfg_last_bytes;
                        beat_cnt     <= '0;
                        pkt_cnt      <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        gap_cnt <= gap_q;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            pkt_cnt  <= last_pkt ? '0 : pkt_cnt + CNT_WIDTH'(1);
                        end else begin
                            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                GAP:  gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                default: gap_cnt <= '0;
            endcase
        end
    end

    // The seed is loaded with the incoming mode so a zero LFSR seed is substituted on load
    assign gen_mode = (state == IDLE) ? mode_t'(cfg_mode) : mode_q;

    axi4s_pattern_gen u_gen (
        .clk   (ACLK),
        .rst   (ARESET),
        .mode  (gen_mode),
        .load  ((state == IDLE) && start_ok),
        .seed  (cfg_seed),
        .adv   ((state == SEND) && hs),
        .value (pat_value)
    );

    assign TDATA = DATA_WIDTH'({REPS{pat_value}});

endmodule
